// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: operand widths and the op record.
package alu_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned ADDR_W = 8;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } op_t;

  // True when either source register matches a pending destination.
  function automatic logic reads_reg(input logic [REG_W-1:0] rs1,
                                     input logic [REG_W-1:0] rs2,
                                     input logic [REG_W-1:0] rd);
    return (rs1 == rd) || (rs2 == rd);
  endfunction

endpackage

// File: rtl/alu_hazard_scoreboard.sv
// Tracks destination registers still in flight to pipeline_alu write-back
// and flags read-after-write hazards for each requester.
module alu_hazard_scoreboard
  import alu_pkg::*;
#(
  parameter int unsigned WB_LAT = 3
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             sh_valid_i,
  input  logic [REG_W-1:0] sh_rd_i,
  input  logic [REG_W-1:0] req0_rs1_i,
  input  logic [REG_W-1:0] req0_rs2_i,
  input  logic [REG_W-1:0] req1_rs1_i,
  input  logic [REG_W-1:0] req1_rs2_i,
  output logic             hazard0_c_o,
  output logic             hazard1_c_o
);

  // Stage 0 is the shift-in itself; only the later stages need storage, so an
  // op granted at edge t can be followed by a dependent op at edge t+WB_LAT.
  localparam int unsigned DEPTH = WB_LAT - 1;

  if (DEPTH > 0) begin : g_stages
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [REG_W-1:0] rd_q [DEPTH];
    logic [REG_W-1:0] rd_d [DEPTH];

    always_comb begin
      valid_d[0] = sh_valid_i;
      rd_d[0]    = sh_rd_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        rd_d[i]    = rd_q[i-1];
      end
    end

    always_ff @(posedge clk1) begin
      if (rst) begin
        valid_q <= '0;
        for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
      end else begin
        valid_q <= valid_d;
        for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
      end
    end

    always_comb begin
      hazard0_c_o = 1'b0;
      hazard1_c_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && reads_reg(req0_rs1_i, req0_rs2_i, rd_q[i])) hazard0_c_o = 1'b1;
        if (valid_q[i] && reads_reg(req1_rs1_i, req1_rs2_i, rd_q[i])) hazard1_c_o = 1'b1;
      end
    end
  end else begin : g_no_stages
    assign hazard0_c_o = 1'b0;
    assign hazard1_c_o = 1'b0;
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing pipeline_alu between two requesters,
// holding back ops that read a register whose write-back is still pending.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [REG_W-1:0]  req0_rs1,
  input  logic [REG_W-1:0]  req0_rs2,
  input  logic [REG_W-1:0]  req0_rd,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [REG_W-1:0]  req1_rs1,
  input  logic [REG_W-1:0]  req1_rs2,
  input  logic [REG_W-1:0]  req1_rd,
  input  logic [FUNC_W-1:0] req1_func,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic [REG_W-1:0]  rd,
  output logic [FUNC_W-1:0] func,
  output logic [ADDR_W-1:0] addr,
  output logic              issue_valid,
  output logic              issue_src,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  op_t              op0, op1, op_q, op_d;
  logic             haz0, haz1, elig0, elig1, gnt0, gnt1, any_gnt;
  logic             ptr_q, ptr_d;
  logic             issue_valid_q, issue_valid_d;
  logic             issue_src_q, issue_src_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign op0 = '{rs1: req0_rs1, rs2: req0_rs2, rd: req0_rd, func: req0_func, addr: req0_addr};
  assign op1 = '{rs1: req1_rs1, rs2: req1_rs2, rd: req1_rd, func: req1_func, addr: req1_addr};

  alu_hazard_scoreboard #(
    .WB_LAT(WB_LAT)
  ) u_sb (
    .clk1        (clk1),
    .rst         (rst),
    .sh_valid_i  (any_gnt),
    .sh_rd_i     (gnt1 ? req1_rd : req0_rd),
    .req0_rs1_i  (req0_rs1),
    .req0_rs2_i  (req0_rs2),
    .req1_rs1_i  (req1_rs1),
    .req1_rs2_i  (req1_rs2),
    .hazard0_c_o (haz0),
    .hazard1_c_o (haz1)
  );

  // Grant: the pointer breaks ties, a lone eligible requester always wins.
  always_comb begin
    elig0 = req0_valid & ~haz0;
    elig1 = req1_valid & ~haz1;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!rst) begin
      if (elig0 && (!elig1 || !ptr_q)) gnt0 = 1'b1;
      else if (elig1)                  gnt1 = 1'b1;
    end
    any_gnt = gnt0 | gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    op_d          = op_q;
    ptr_d         = ptr_q;
    issue_src_d   = issue_src_q;
    issue_valid_d = any_gnt;
    issue_cnt_d   = issue_cnt_q + CNT_W'(any_gnt);
    stall_cnt_d   = stall_cnt_q;
    if (gnt0) begin
      op_d        = op0;
      issue_src_d = 1'b0;
      ptr_d       = 1'b1;
    end else if (gnt1) begin
      op_d        = op1;
      issue_src_d = 1'b1;
      ptr_d       = 1'b0;
    end
    if ((req0_valid || req1_valid) && !any_gnt) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      op_q          <= '0;
      ptr_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_src_q   <= 1'b0;
      issue_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      op_q          <= op_d;
      ptr_q         <= ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_src_q   <= issue_src_d;
      issue_cnt_q   <= issue_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign rs1         = op_q.rs1;
  assign rs2         = op_q.rs2;
  assign rd          = op_q.rd;
  assign func        = op_q.func;
  assign addr        = op_q.addr;
  assign issue_valid = issue_valid_q;
  assign issue_src   = issue_src_q;
  assign issue_cnt   = issue_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed vector bench for alu_issue_arbiter: reset, fairness, RAW stalls,
// hazard bypass, counter wrap and reset while producers are in flight.
module tb_alu_issue_arbiter;
  import alu_pkg::*;

  localparam int unsigned WB_LAT = 3;
  localparam int unsigned CNT_W  = 4;

  logic              clk1, rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [REG_W-1:0]  req0_rs1, req0_rs2, req0_rd, req1_rs1, req1_rs2, req1_rd;
  logic [FUNC_W-1:0] req0_func, req1_func;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [REG_W-1:0]  rs1, rs2, rd;
  logic [FUNC_W-1:0] func;
  logic [ADDR_W-1:0] addr;
  logic              issue_valid, issue_src;
  logic [CNT_W-1:0]  issue_cnt, stall_cnt;

  alu_issue_arbiter #(.WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
    .clk1(clk1), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rd(req0_rd),
    .req0_func(req0_func), .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rd(req1_rd),
    .req1_func(req1_func), .req1_addr(req1_addr),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .issue_valid(issue_valid), .issue_src(issue_src),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic rst;
    logic v0;
    op_t  op0;
    logic v1;
    op_t  op1;
    logic er0;
    logic er1;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  op_t              exp_op;
  logic             exp_iv, exp_src;
  logic [CNT_W-1:0] exp_ic, exp_sc;
  op_t              nop;

  function automatic op_t mk(input logic [3:0] a_rs1, input logic [3:0] a_rs2,
                             input logic [3:0] a_rd, input logic [3:0] a_func,
                             input logic [7:0] a_addr);
    op_t o;
    o.rs1  = a_rs1;
    o.rs2  = a_rs2;
    o.rd   = a_rd;
    o.func = a_func;
    o.addr = a_addr;
    return o;
  endfunction

  task automatic add(input logic r, input logic v0, input op_t o0,
                     input logic v1, input op_t o1, input logic e0, input logic e1);
    vec_t v;
    v.rst = r;  v.v0 = v0; v.op0 = o0; v.v1 = v1; v.op1 = o1;
    v.er0 = e0; v.er1 = e1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    nop = mk(4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // Reset held two edges with both requesters valid, then one idle cycle.
    add(1, 1, mk(4'h1, 4'h2, 4'h3, 4'h4, 8'h55), 1, mk(4'h6, 4'h7, 4'h8, 4'h9, 8'haa), 0, 0);
    add(1, 1, mk(4'h1, 4'h2, 4'h3, 4'h4, 8'h55), 1, mk(4'h6, 4'h7, 4'h8, 4'h9, 8'haa), 0, 0);
    add(0, 0, nop, 0, nop, 0, 0);

    // Single issue from requester 0.
    add(0, 1, mk(4'ha, 4'h5, 4'h3, 4'h1, 8'h0a), 0, nop, 1, 0);
    add(0, 0, nop, 0, nop, 0, 0);
    add(0, 0, nop, 0, nop, 0, 0);
    add(0, 0, nop, 0, nop, 0, 0);

    // Fairness: independent streams alternate 0,1,0,1.
    add(1, 0, nop, 0, nop, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, mk(4'h0, 4'h1, 4'h4, 4'h2, 8'(8'h40 + i)),
             1, mk(4'h2, 4'h3, 4'h5, 4'h3, 8'(8'h50 + i)),
             (i % 2) == 0, (i % 2) == 1);

    // RAW: consumer of r3 stalls two edges, accepted at t+WB_LAT.
    add(1, 0, nop, 0, nop, 0, 0);
    add(0, 1, mk(4'h1, 4'h2, 4'h3, 4'h5, 8'h13), 0, nop, 1, 0);
    add(0, 0, nop, 1, mk(4'h3, 4'h4, 4'h6, 4'h6, 8'h36), 0, 0);
    add(0, 0, nop, 1, mk(4'h3, 4'h4, 4'h6, 4'h6, 8'h36), 0, 0);
    add(0, 0, nop, 1, mk(4'h3, 4'h4, 4'h6, 4'h6, 8'h36), 0, 1);

    // Bypass: req0 blocked on rs2=r9 while pointer favours it; req1 overtakes.
    add(1, 0, nop, 0, nop, 0, 0);
    add(0, 0, nop, 1, mk(4'h1, 4'h1, 4'h9, 4'h7, 8'h91), 0, 1);
    add(0, 1, mk(4'h2, 4'h9, 4'ha, 4'h8, 8'ha2), 1, mk(4'h4, 4'h5, 4'hb, 4'h9, 8'hb4), 0, 1);
    add(0, 1, mk(4'h2, 4'h9, 4'ha, 4'h8, 8'ha2), 1, mk(4'h6, 4'h7, 4'hc, 4'ha, 8'hc6), 0, 1);
    add(0, 1, mk(4'h2, 4'h9, 4'ha, 4'h8, 8'ha2), 1, mk(4'hd, 4'he, 4'hf, 4'hb, 8'hfd), 1, 0);
    add(0, 0, nop, 1, mk(4'hd, 4'he, 4'hf, 4'hb, 8'hfd), 0, 1);

    // Counter wrap: 17 grants on a 4-bit counter.
    add(1, 0, nop, 0, nop, 0, 0);
    for (int i = 0; i < 17; i++)
      add(0, 1, mk(4'h0, 4'h0, 4'h1, 4'h2, 8'(i)), 0, nop, 1, 0);

    // Producer of r7, reset mid-flight, consumer accepted right after reset.
    add(0, 1, mk(4'h0, 4'h0, 4'h7, 4'h3, 8'h77), 0, nop, 1, 0);
    add(1, 0, nop, 1, mk(4'h7, 4'h0, 4'h2, 4'h4, 8'h22), 0, 0);
    add(0, 0, nop, 1, mk(4'h7, 4'h0, 4'h2, 4'h4, 8'h22), 0, 1);

    exp_op = nop; exp_iv = 1'b0; exp_src = 1'b0; exp_ic = '0; exp_sc = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst        = vecs[i].rst;
      req0_valid = vecs[i].v0;
      req1_valid = vecs[i].v1;
      {req0_rs1, req0_rs2, req0_rd, req0_func, req0_addr} = vecs[i].op0;
      {req1_rs1, req1_rs2, req1_rd, req1_func, req1_addr} = vecs[i].op1;
      #1;
      chk($sformatf("req0_ready[%0d]", i), 32'(req0_ready), 32'(vecs[i].er0));
      chk($sformatf("req1_ready[%0d]", i), 32'(req1_ready), 32'(vecs[i].er1));
      @(posedge clk1);
      #1;
      if (vecs[i].rst) begin
        exp_op = nop; exp_iv = 1'b0; exp_src = 1'b0; exp_ic = '0; exp_sc = '0;
      end else begin
        exp_iv = vecs[i].er0 | vecs[i].er1;
        if (vecs[i].er0) begin
          exp_op = vecs[i].op0; exp_src = 1'b0;
        end else if (vecs[i].er1) begin
          exp_op = vecs[i].op1; exp_src = 1'b1;
        end
        if (exp_iv) exp_ic = exp_ic + CNT_W'(1);
        else if (vecs[i].v0 || vecs[i].v1) exp_sc = exp_sc + CNT_W'(1);
      end
      chk($sformatf("op_fields[%0d]", i), 32'({rs1, rs2, rd, func, addr}), 32'(exp_op));
      chk($sformatf("issue_valid[%0d]", i), 32'(issue_valid), 32'(exp_iv));
      chk($sformatf("issue_src[%0d]", i), 32'(issue_src), 32'(exp_src));
      chk($sformatf("issue_cnt[%0d]", i), 32'(issue_cnt), 32'(exp_ic));
      chk($sformatf("stall_cnt[%0d]", i), 32'(stall_cnt), 32'(exp_sc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
Issue controller in front of pipeline_alu, sharing it between two requesters.
- Each requester offers one ALU op per valid/ready handshake.
- The block picks an op by round-robin, blocks read-after-write hazards, and drives the registered operand fields into the ALU.
- pipeline_alu has no forwarding. A dependent op is held back until the producer's register write-back has completed.

Parameters:
- WB_LAT, 3: accept-edges before a destination register is readable. Valid range 1..7.
- CNT_W, 16: width of the performance counters.

Ports:
- clk1  in  1  single system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle. Combinational.
- req0_rs1, req0_rs2, req0_rd, req0_func  in  4 each  requester 0 op fields.
- req0_addr  in  8  requester 0 memory address.
- req1_valid, req1_ready, req1_rs1, req1_rs2, req1_rd, req1_func, req1_addr: same as requester 0, for requester 1.
- rs1, rs2, rd, func  out  4 each  registered op fields to pipeline_alu.
- addr  out  8  registered memory address to pipeline_alu.
- issue_valid  out  1  rs1..addr carry a real op this cycle.
- issue_src  out  1  requester index of the current issued op.
- issue_cnt  out  CNT_W  number of ops accepted.
- stall_cnt  out  CNT_W  cycles with a request pending but nothing accepted.

Behaviour:
- Reset (sampled at clk1 edge while rst=1):
  - rs1, rs2, rd, func, addr, issue_valid, issue_src, issue_cnt, stall_cnt all go to 0.
  - Round-robin pointer goes to requester 0.
  - All scoreboard entries are cleared.
  - req*_ready is 0 while rst=1.
- Reset mid-operation: in-flight scoreboard entries are discarded. The first op after reset is never hazard-blocked.
- Handshake:
  - Accept happens when valid & ready at a clk1 edge.
  - A requester holds its fields stable while valid & !ready.
  - valid may not drop without acceptance.
- Eligibility: requester i is eligible when valid is high and neither rs1 nor rs2 matches the rd of any valid scoreboard entry.
- Grant:
  - At most one ready per cycle.
  - If both are eligible, the pointer's requester wins.
  - If only one is eligible, it wins regardless of the pointer.
  - The pointer moves to the non-granted requester after each grant and is unchanged on no grant.
- Latency: fields accepted at edge t appear on rs1..addr with issue_valid=1 and issue_src set, from t until t+1. No combinational path from req fields to the ALU outputs.
- No grant: issue_valid=0 and rs1..addr hold their previous values. The pipeline_alu wrapper gates register and memory writes with issue_valid, carried along its stages.
- Scoreboard:
  - WB_LAT-deep shift register of {valid, rd}. It shifts every cycle.
  - On a grant the accepted rd enters stage 0 with valid=1; otherwise valid=0 enters.
  - An entry ages out after WB_LAT edges.
  - Consequence: a dependent op is accepted no earlier than edge t+WB_LAT.
  - Hazard is checked on rs1 and rs2 only. WAW is not blocked, since in-order write-back is guaranteed. An op whose rd equals its own rs is legal.
- Counters:
  - issue_cnt increments on each grant.
  - stall_cnt increments on each edge where any req valid=1 and no grant.
  - Both wrap modulo 2^CNT_W (all-ones to 0).

Decomposition:
- Shared package alu_pkg:
  - REG_W=4, FUNC_W=4, ADDR_W=8.
  - Op record typedef {rs1, rs2, rd, func, addr}.
  - Reused by pipeline_alu and benches.
- One sub-module, alu_hazard_scoreboard:
  - Inputs: shift-in valid/rd, and rs1/rs2 for each requester.
  - Outputs: per-requester hazard flags.
  - Contains the WB_LAT shift register.

Test Plan:
1. Reset: rst=1 for 2 edges with both req valid → readys 0 throughout; after release all outputs are 0 and issue_valid=0.
2. Single issue: req0 {rs1=A, rs2=5, rd=3, func=1, addr=0A} → req0_ready=1 same cycle; next cycle rs1=A, rs2=5, rd=3, func=1, addr=0A, issue_valid=1, issue_src=0, issue_cnt=1.
3. Fairness: both requesters continuously valid with independent regs (req0 writes r4 reading r0/r1; req1 writes r5 reading r2/r3) → grants alternate 0,1,0,1; issue_cnt=4 after 4 edges; stall_cnt=0.
4. RAW stall: req0 rd=3 accepted at edge 0; req1 rs1=3 valid from cycle 1 → req1_ready=0 at edges 1,2, accepted at edge 3; stall_cnt=2; issue_valid=0 for 2 cycles.
5. Bypass: req0 blocked (rs2 equals a pending rd) and pointer=0, req1 independent → req1 granted immediately and pointer moves to 0. req0 is granted once its hazard clears.
6. Wrap and mid-op reset: CNT_W=4, 17 grants → issue_cnt=1. Then a producer with rd=7 is accepted, followed by rst 1 edge, then a consumer with rs1=7 → consumer accepted on the first edge after reset.
